interrupt_controller: RTL and testbench

//  Parametrised multi-channel interrupt controller. It replaces the single ad-hoc 'int' line of the 5-stage core.
//  Per channel it detects rising edges, latches pending requests, applies a mask and picks the winner by fixed priority.
//  It then runs the entry sequence: drain, push PC, push CCR, vector the PC.

---
 rtl/interrupt_controller.sv | 218 +++++++++++++++++++++
 tb/tb_interrupt_controller.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_controller.sv
// interrupt_controller: multi-channel interrupt controller for the 5-stage core.
// Rising-edge request latching, mask, fixed priority (index 0 highest), and
// the entry sequence drain -> push PC -> push CCR -> vector -> service.
// Optional feature macro: INTC_NESTING_EN (higher-priority requests may
// preempt a handler in service).
//
// state      | meaning
// -----------+----------------------------------------------------------
// S_IDLE     | no sequence running, waiting for an unmasked pending winner
// S_DRAIN    | fetch frozen while the pipeline drains, down-counter runs
// S_PUSH_PC  | memory stage pushes the PC (one cycle)
// S_PUSH_CCR | memory stage pushes the CCR (one cycle)
// S_VECTOR   | PC loaded with the handler vector, channel marked in service
// S_SERVICE  | handler running, waiting for RTI retirement
module interrupt_controller #(
   parameter int          ID_W         = 2,
   parameter int          ADDR_W       = 32,
   parameter int          DRAIN_CYCLES = 4,
   parameter int unsigned VEC_BASE     = 0,
   parameter int unsigned VEC_STRIDE   = 2
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic [(1<<ID_W)-1:0] i_irq,
   input  logic                 i_mask_wr,
   input  logic [(1<<ID_W)-1:0] i_mask_data,
   input  logic                 i_rti,
   output logic                 o_fetch_stall,
   output logic                 o_push_pc,
   output logic                 o_push_ccr,
   output logic                 o_pc_load,
   output logic [ADDR_W-1:0]    o_pc_vector,
   output logic                 o_irq_active,
   output logic [ID_W-1:0]      o_irq_id,
   output logic [(1<<ID_W)-1:0] o_pending
);

   localparam int N_IRQ = 1 << ID_W;
   localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [CNT_W-1:0] DRAIN_INIT = CNT_W'(DRAIN_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_DRAIN    = 3'd1,
      S_PUSH_PC  = 3'd2,
      S_PUSH_CCR = 3'd3,
      S_VECTOR   = 3'd4,
      S_SERVICE  = 3'd5
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic [ID_W-1:0]    r_id;
   logic [ID_W-1:0]    w_id_nxt;
   logic [N_IRQ-1:0]   r_in_service;
   logic [N_IRQ-1:0]   w_in_service_nxt;
   logic [N_IRQ-1:0]   r_irq_q;
   logic [N_IRQ-1:0]   r_pending;
   logic [N_IRQ-1:0]   r_mask;
   logic [N_IRQ-1:0]   w_pending_set;
   logic [N_IRQ-1:0]   w_pending_clr;
   logic [N_IRQ-1:0]   w_eligible;
   logic               w_win_vld;
   logic [ID_W-1:0]    w_win_id;
   logic [ID_W-1:0]    w_srv_id;
   logic [ADDR_W-1:0]  w_vec;
   logic               w_in_seq;

   logic               r_fetch_stall;
   logic               r_push_pc;
   logic               r_push_ccr;
   logic               r_pc_load;
   logic [ADDR_W-1:0]  r_pc_vector;
   logic               r_irq_active;
   logic [ID_W-1:0]    r_irq_id;

   function automatic logic [N_IRQ-1:0] onehot(input logic [ID_W-1:0] id);
      return N_IRQ'(1) << id;
   endfunction

   // index of the lowest set bit (0 when none is set)
   function automatic logic [ID_W-1:0] lowest(input logic [N_IRQ-1:0] v);
      logic [ID_W-1:0] res;
      res = '0;
      for (int i = N_IRQ - 1; i >= 0; i--) begin
         if (v[i]) res = ID_W'(i);
      end
      return res;
   endfunction

   assign w_pending_set = i_irq & ~r_irq_q;
   assign w_eligible    = r_pending & ~r_mask;
   assign w_win_vld     = |w_eligible;
   assign w_win_id      = lowest(w_eligible);
   assign w_vec         = ADDR_W'(VEC_BASE) + ADDR_W'(r_id) * ADDR_W'(VEC_STRIDE);

   // Edge detect, pending latches (set beats clear) and mask register
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_irq_q   <= '0;
         r_pending <= '0;
         r_mask    <= '0;
      end else begin
         r_irq_q   <= i_irq;
         r_pending <= (r_pending & ~w_pending_clr) | w_pending_set;
         if (i_mask_wr) r_mask <= i_mask_data;
      end
   end

   // FSM state, drain counter, latched id and in-service bits
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_id         <= '0;
         r_in_service <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_id         <= w_id_nxt;
         r_in_service <= w_in_service_nxt;
      end
   end

   // Next-state logic; an accepted winner has its pending bit cleared
   always_comb begin
      w_state_nxt      = r_state;
      w_cnt_nxt        = r_cnt;
      w_id_nxt         = r_id;
      w_in_service_nxt = r_in_service;
      w_pending_clr    = '0;
      case (r_state)
         S_IDLE: begin
            if (w_win_vld) begin
               w_id_nxt      = w_win_id;
               w_pending_clr = onehot(w_win_id);
               w_cnt_nxt     = DRAIN_INIT;
               w_state_nxt   = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (r_cnt == '0) w_state_nxt = S_PUSH_PC;
            else             w_cnt_nxt   = r_cnt - 1'b1;
         end
         S_PUSH_PC:  w_state_nxt = S_PUSH_CCR;
         S_PUSH_CCR: w_state_nxt = S_VECTOR;
         S_VECTOR: begin
            w_in_service_nxt = r_in_service | onehot(r_id);
            w_state_nxt      = S_SERVICE;
         end
         S_SERVICE: begin
`ifdef INTC_NESTING_EN
            // The lowest in-service bit is the handler currently running;
            // RTI retires it and resumes any preempted handler.
            if (i_rti) begin
               w_in_service_nxt = r_in_service & ~onehot(lowest(r_in_service));
               if (w_in_service_nxt == '0) w_state_nxt = S_IDLE;
            end else if (w_win_vld && (w_win_id < lowest(r_in_service))) begin
               w_id_nxt      = w_win_id;
               w_pending_clr = onehot(w_win_id);
               w_cnt_nxt     = DRAIN_INIT;
               w_state_nxt   = S_DRAIN;
            end
`else
            if (i_rti) begin
               w_in_service_nxt = r_in_service & ~onehot(r_id);
               w_state_nxt      = S_IDLE;
            end
`endif
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

`ifdef INTC_NESTING_EN
   assign w_srv_id = lowest(w_in_service_nxt);
`else
   assign w_srv_id = w_id_nxt;
`endif

   assign w_in_seq = (w_state_nxt == S_DRAIN) || (w_state_nxt == S_PUSH_PC) ||
                     (w_state_nxt == S_PUSH_CCR) || (w_state_nxt == S_VECTOR);

   // Registered outputs decoded from the next state, so none depends on irq combinationally
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_fetch_stall <= 1'b0;
         r_push_pc     <= 1'b0;
         r_push_ccr    <= 1'b0;
         r_pc_load     <= 1'b0;
         r_pc_vector   <= '0;
         r_irq_active  <= 1'b0;
         r_irq_id      <= '0;
      end else begin
         r_fetch_stall <= w_in_seq;
         r_push_pc     <= (w_state_nxt == S_PUSH_PC);
         r_push_ccr    <= (w_state_nxt == S_PUSH_CCR);
         r_pc_load     <= (w_state_nxt == S_VECTOR);
         r_pc_vector   <= (w_state_nxt == S_VECTOR) ? w_vec : '0;
         r_irq_active  <= (w_state_nxt == S_SERVICE);
         if (w_state_nxt == S_SERVICE) r_irq_id <= w_srv_id;
         else if (w_in_seq)            r_irq_id <= w_id_nxt;
         else                          r_irq_id <= '0;
      end
   end

   assign o_fetch_stall = r_fetch_stall;
   assign o_push_pc     = r_push_pc;
   assign o_push_ccr    = r_push_ccr;
   assign o_pc_load     = r_pc_load;
   assign o_pc_vector   = r_pc_vector;
   assign o_irq_active  = r_irq_active;
   assign o_irq_id      = r_irq_id;
   assign o_pending     = r_pending;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller with default parameters
// (4 channels, DRAIN_CYCLES=4, VEC_BASE=0, VEC_STRIDE=2).
module tb_interrupt_controller;

   logic        clk;
   logic        reset;
   logic [3:0]  irq;
   logic        mask_wr;
   logic [3:0]  mask_data;
   logic        rti;
   logic        fetch_stall;
   logic        push_pc;
   logic        push_ccr;
   logic        pc_load;
   logic [31:0] pc_vector;
   logic        irq_active;
   logic [1:0]  irq_id;
   logic [3:0]  pending;

   int total = 0;
   int bad   = 0;
   int cnt;

   interrupt_controller dut (
      .i_clk         (clk),
      .i_reset       (reset),
      .i_irq         (irq),
      .i_mask_wr     (mask_wr),
      .i_mask_data   (mask_data),
      .i_rti         (rti),
      .o_fetch_stall (fetch_stall),
      .o_push_pc     (push_pc),
      .o_push_ccr    (push_ccr),
      .o_pc_load     (pc_load),
      .o_pc_vector   (pc_vector),
      .o_irq_active  (irq_active),
      .o_irq_id      (irq_id),
      .o_pending     (pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic rti_pulse();
      rti = 1'b1;
      step();
      rti = 1'b0;
   endtask

   // Called right after the step in which the winner is visible in IDLE
   // (or SERVICE): waits for pc_load and checks latency, vector and id.
   task automatic expect_entry(input string tag, input int exp_lat,
                               input logic [31:0] exp_vec, input logic [31:0] exp_id);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (!pc_load && n < 30);
      chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
      chk({tag, "_vec"}, pc_vector, exp_vec);
      chk({tag, "_load_id"}, 32'(irq_id), exp_id);
      step();
      chk({tag, "_active"}, 32'(irq_active), 32'd1);
      chk({tag, "_srv_id"}, 32'(irq_id), exp_id);
      chk({tag, "_stall_off"}, 32'(fetch_stall), 32'd0);
   endtask

   initial begin
      reset = 1'b1; irq = '0; mask_wr = 1'b0; mask_data = '0; rti = 1'b0;
      step();
      step();
      chk("rst_stall",   32'(fetch_stall), 32'd0);
      chk("rst_pending", 32'(pending),     32'd0);
      chk("rst_vector",  pc_vector,        32'd0);
      chk("rst_active",  32'(irq_active),  32'd0);
      reset = 1'b0;
      step();

      // Single request on channel 2: cycle-exact entry timeline
      irq = 4'b0100;
      for (int k = 1; k <= 9; k++) begin
         step();
         chk($sformatf("t2_stall_%0d", k), 32'(fetch_stall), 32'(k >= 2 && k <= 8));
         chk($sformatf("t2_pushpc_%0d", k), 32'(push_pc), 32'(k == 6));
         chk($sformatf("t2_pushccr_%0d", k), 32'(push_ccr), 32'(k == 7));
         chk($sformatf("t2_pcload_%0d", k), 32'(pc_load), 32'(k == 8));
         if (k == 1) chk("t2_pending", 32'(pending), 32'h4);
         if (k == 8) begin
            chk("t2_vec", pc_vector, 32'd4);
            chk("t2_id", 32'(irq_id), 32'd2);
         end
         if (k == 9) chk("t2_active", 32'(irq_active), 32'd1);
      end
      irq = '0;
      rti_pulse();
      chk("t2_ret_active", 32'(irq_active), 32'd0);

      // Reset asserted mid-DRAIN aborts without any push
      irq = 4'b0010;
      step();
      step();
      step();
      chk("t1_in_drain", 32'(fetch_stall), 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("t1_async_stall", 32'(fetch_stall), 32'd0);
      chk("t1_async_pending", 32'(pending), 32'd0);
      irq = '0;
      step();
      reset = 1'b0;
      cnt = 0;
      for (int k = 0; k < 12; k++) begin
         step();
         if (push_pc || push_ccr || pc_load) cnt++;
      end
      chk("t1_no_push", 32'(cnt), 32'd0);
      chk("t1_pending", 32'(pending), 32'd0);

      // Simultaneous requests on 1 and 3: 1 first, 3 after rti
      irq = 4'b1010;
      step();
      chk("t3_pending_both", 32'(pending), 32'hA);
      expect_entry("t3_ch1", 7, 32'd2, 32'd1);
      chk("t3_pending_3", 32'(pending), 32'h8);
      irq = '0;
      rti_pulse();
      chk("t3_idle", 32'(irq_active), 32'd0);
      expect_entry("t3_ch3", 7, 32'd6, 32'd3);
      chk("t3_pending_none", 32'(pending), 32'd0);
      rti_pulse();

      // Masked request stays pending; unmasking starts the sequence
      mask_wr = 1'b1; mask_data = 4'b0001;
      step();
      mask_wr = 1'b0;
      irq = 4'b0001;
      step();
      chk("t4_pending", 32'(pending), 32'h1);
      step(); step(); step();
      chk("t4_masked_stall", 32'(fetch_stall), 32'd0);
      chk("t4_masked_pending", 32'(pending), 32'h1);
      irq = '0;
      step();
      mask_wr = 1'b1; mask_data = 4'b0000;
      step();
      mask_wr = 1'b0;
      chk("t4_unmask_stall", 32'(fetch_stall), 32'd0);
      // channel 0 rises again in the very cycle its pending bit is accepted
      irq = 4'b0001;
      step();
      chk("t4_start_stall", 32'(fetch_stall), 32'd1);
      chk("t4_set_wins", 32'(pending), 32'h1);
      expect_entry("t4_ch0", 6, 32'd0, 32'd0);
      rti_pulse();
      expect_entry("t4_ch0_again", 7, 32'd0, 32'd0);
      chk("t4_pending_none", 32'(pending), 32'd0);
      irq = '0;
      rti_pulse();

      // rti while idle is ignored; a held level yields a single entry
      rti_pulse();
      chk("t5_rti_stall", 32'(fetch_stall), 32'd0);
      chk("t5_rti_active", 32'(irq_active), 32'd0);
      chk("t5_rti_pending", 32'(pending), 32'd0);
      irq = 4'b0100;
      cnt = 0;
      for (int k = 0; k < 10; k++) begin
         step();
         if (pc_load) cnt++;
      end
      rti = 1'b1;
      step();
      rti = 1'b0;
      for (int k = 0; k < 12; k++) begin
         step();
         if (pc_load) cnt++;
         if (k == 6) irq = '0;
      end
      chk("t5_one_entry", 32'(cnt), 32'd1);
      chk("t5_idle", 32'(irq_active), 32'd0);
      chk("t5_pending", 32'(pending), 32'd0);

      // Higher-priority request while channel 2 is in service
      irq = 4'b0100;
      step();
      expect_entry("t6_ch2", 7, 32'd4, 32'd2);
      irq = 4'b0001;
      step();
      chk("t6_pending0", 32'(pending), 32'h1);
`ifdef INTC_NESTING_EN
      expect_entry("t6_nest", 7, 32'd0, 32'd0);
      chk("t6_nest_pending", 32'(pending), 32'd0);
      rti_pulse();
      chk("t6_resume_active", 32'(irq_active), 32'd1);
      chk("t6_resume_id", 32'(irq_id), 32'd2);
      chk("t6_resume_stall", 32'(fetch_stall), 32'd0);
      rti_pulse();
      chk("t6_final_active", 32'(irq_active), 32'd0);
      chk("t6_final_id", 32'(irq_id), 32'd0);
`else
      cnt = 0;
      for (int k = 0; k < 10; k++) begin
         step();
         if (pc_load || fetch_stall) cnt++;
      end
      chk("t6_no_preempt", 32'(cnt), 32'd0);
      chk("t6_still_pending", 32'(pending), 32'h1);
      chk("t6_still_id", 32'(irq_id), 32'd2);
      rti_pulse();
      chk("t6_rti_idle", 32'(irq_active), 32'd0);
      expect_entry("t6_ch0", 7, 32'd0, 32'd0);
      chk("t6_pending_none", 32'(pending), 32'd0);
      rti_pulse();
      chk("t6_final_active", 32'(irq_active), 32'd0);
`endif
      irq = '0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
